// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, input synchronizer and a small
// first-word-fall-through FIFO on the host read side.
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int CW    = (DVSR > 2) ? $clog2(DVSR) : 1;
    localparam int SW    = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 1 << FIFO_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic rx_meta;
    logic rx_s;

    // Synchronizer presets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [SW-1:0]   s;
    logic [SW-1:0]   s_n;
    logic [NW-1:0]   n;
    logic [NW-1:0]   n_n;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_n;
    logic            done;

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == SW'(7)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == SW'(15)) begin
                        b_n = {rx_s, b[DBIT-1:1]};
                        s_n = '0;
                        if (n == NW'(DBIT - 1)) begin
                            state_n = STOP;
                        end else begin
                            n_n = n + NW'(1);
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
        end
    end

    logic push;
    logic rd_en;
    logic wr_en;

    // A pop in the decision cycle frees a slot, so a full FIFO still accepts.
    assign push  = done && rx_s;
    assign rd_en = rd_uart && !rx_empty;
    assign wr_en = push && (!rx_full || rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= done && !rx_s;
            overrun   <= push && rx_full && !rd_en;
        end
    end

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;

    assign r_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10: begin
                    wr_ptr   <= wr_ptr + FIFO_W'(1);
                    rx_empty <= 1'b0;
                    rx_full  <= ((wr_ptr + FIFO_W'(1)) == rd_ptr);
                end
                2'b01: begin
                    rd_ptr   <= rd_ptr + FIFO_W'(1);
                    rx_full  <= 1'b0;
                    rx_empty <= ((rd_ptr + FIFO_W'(1)) == wr_ptr);
                end
                2'b11: begin
                    wr_ptr <= wr_ptr + FIFO_W'(1);
                    rd_ptr <= rd_ptr + FIFO_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, popped words and
// error pulses checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR    = 4;
    localparam int FIFO_W  = 2;
    localparam int DEPTH   = 1 << FIFO_W;
    localparam int BITC    = 16 * DVSR;
    localparam int NT      = 8 + 16 * DBIT + SB_TICK;
    localparam int EV_FE   = 1;
    localparam int EV_OVR  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            rx = 1'b1;
    logic            rd_uart = 1'b0;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;
    logic            frame_err;
    logic            overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DBIT(DBIT),
        .SB_TICK(SB_TICK),
        .DVSR(DVSR),
        .FIFO_W(FIFO_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rd_uart(rd_uart),
        .r_data(r_data),
        .rx_empty(rx_empty),
        .rx_full(rx_full),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    int compared = 0;
    int mismatched = 0;
    logic [7:0] model_q[$];
    int ev_q[$];
    int phase;

    // Free-running oversample tick position, restarted only by reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) phase <= 0;
        else phase <= (phase == DVSR - 1) ? 0 : phase + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_empty"}, rx_empty, model_q.size() == 0);
        chk({tag, "_full"}, rx_full, model_q.size() == DEPTH);
        if (model_q.size() > 0) chk({tag, "_head"}, r_data, model_q[0]);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (reset) begin
            if (rd_uart && !rx_empty) begin
                e = (model_q.size() > 0) ? 32'(model_q.pop_front()) : 32'hdead;
                chk("pop_data", r_data, e);
            end
            if (frame_err || overrun) begin
                e = (ev_q.size() > 0) ? 32'(ev_q.pop_front()) : 32'h0;
                chk("event", {30'b0, overrun, frame_err}, e);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit pop_dec, input bit chk_lat);
        logic [DBIT+1:0] fr;
        int nt;
        int bp;
        bit lat_pend;
        fr = {1'b1, d, 1'b0};
        nt = 0;
        lat_pend = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < (DBIT + 2) * BITC; c++) begin
            bp = c / BITC;
            rx = fr[bp];
            // A bad stop bit is held low only long enough to cover its sample.
            if (bp == DBIT + 1 && !stop_ok && (c % BITC) < 12 * DVSR) rx = 1'b0;
            rd_uart = 1'b0;
            if (lat_pend) begin
                chk("lat_post_empty", rx_empty, 0);
                chk("lat_post_data", r_data, d);
                lat_pend = 0;
            end
            if (c >= 3 && nt < NT && phase == DVSR - 1) begin
                nt++;
                if (nt == NT) begin
                    if (!stop_ok) ev_q.push_back(EV_FE);
                    else if (model_q.size() >= DEPTH && !pop_dec)
                        ev_q.push_back(EV_OVR);
                    else model_q.push_back(d);
                    if (pop_dec) rd_uart = 1'b1;
                    if (chk_lat) begin
                        chk("lat_pre_empty", rx_empty, 1);
                        lat_pend = 1;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        rd_uart = 1'b0;
        rx = 1'b1;
        if (!stop_ok) begin
            repeat (24 * DVSR) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_one();
        rd_uart = 1'b1;
        @(posedge clk);
        #1;
        rd_uart = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2 * DEPTH + 2 && model_q.size() > 0; k++) pop_one();
        check_state(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, rx_empty, 1);
        chk({tag, "_full"}, rx_full, 0);
        chk({tag, "_rdata"}, r_data, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DBIT+1:0] fr;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        send_frame(8'hA5, 1, 0, 1);
        check_state("single");
        drain("single_drain");

        rx = 1'b0;
        repeat (4 * DVSR) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20 * DVSR) @(posedge clk);
        #1;
        check_state("glitch");

        send_frame(8'h3C, 0, 0, 0);
        check_state("ferr");
        send_frame(8'h5A, 1, 0, 0);
        check_state("after_ferr");
        drain("after_ferr_drain");

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1, 0, 0);
            if (i >= 4) check_state("fill");
        end
        drain("fill_drain");

        rd_uart = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_state("pop_empty");
        rd_uart = 1'b0;
        send_frame(8'h11, 1, 0, 0);
        check_state("pop_empty_next");
        drain("pop_empty_drain");

        for (int i = 0; i < DEPTH; i++) send_frame(8'h21 + 8'(i), 1, 0, 0);
        send_frame(8'h25, 1, 1, 0);
        check_state("pop_push_full");
        drain("pop_push_drain");

        send_frame(8'h77, 1, 0, 0);
        fr = {1'b1, 8'h99, 1'b0};
        @(posedge clk);
        #1;
        for (int c = 0; c < 4 * BITC + 8 * DVSR; c++) begin
            rx = fr[c / BITC];
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_q.delete();
        rx = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20 * DVSR) @(posedge clk);
        #1;
        check_state("midrst_idle");
        send_frame(8'hC3, 1, 0, 0);
        check_state("midrst_next");
        drain("midrst_drain");

        for (int it = 0; it < 14; it++) begin
            int np;
            logic [7:0] d;
            bit ok;
            d = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_frame(d, ok, 0, 0);
            check_state("rand");
            np = $urandom_range(0, 2);
            for (int k = 0; k < np && model_q.size() > 0; k++) pop_one();
        end
        drain("final_drain");
        repeat (4) @(posedge clk);
        #1;
        chk("pending_events", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
                 mismatched);
        $finish;
    end

endmodule
